ahb_lite_sram_slave: RTL
========================

AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word-address width (memory depth 2**ADDR_W x 32 bits).
REQ-002 SHALL have parameter WAIT_STATES, default 0, range 0..7, wait cycles inserted per OKAY data phase.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port HCLK  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port HRESET  in  1  asynchronous reset, active high.
REQ-006 SHALL have port HSEL  in  1  slave select.
REQ-007 SHALL have port HADDR  in  32  byte address, sampled in the address phase.
REQ-008 SHALL have port HTRANS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 SHALL have port HWRITE  in  1  1 = write, 0 = read.
REQ-010 SHALL have port HSIZE  in  3  transfer size; only 010 (word) is legal.
REQ-011 SHALL have port HWDATA  in  32  write data, valid in the data phase.
REQ-012 SHALL have port HREADY  in  1  bus-wide ready; previous transfer complete.
REQ-013 SHALL have port HREADYOUT  out  1  this slave's ready.
REQ-014 SHALL have port HRESP  out  1  0 = OKAY, 1 = ERROR.
REQ-015 SHALL have port HRDATA  out  32  read data.

Function
REQ-016 SHALL accept a transfer at a rising HCLK edge only when HSEL=1, HREADY=1 and HTRANS[1]=1; it then latches HADDR[ADDR_W+1:2], HWRITE and the error flag.
REQ-017 SHALL treat IDLE/BUSY, or HSEL=0, as no transfer: zero-wait OKAY (HREADYOUT=1, HRESP=0), no memory change.
REQ-018 SHALL flag an error when HSIZE!=010, HADDR[1:0]!=00, or HADDR[31:ADDR_W+2]!=0.
REQ-019 SHALL implement FSM states IDLE, WAIT, LAST, ERR1, ERR2.
REQ-020 SHALL take these transitions on accept: error -> ERR1; WAIT_STATES>0 -> WAIT with counter=WAIT_STATES-1; otherwise -> LAST. With no accept, go to IDLE.
REQ-021 SHALL, in WAIT, drive HREADYOUT=0 and HRESP=0; at counter=0 go to LAST, else decrement.
REQ-022 SHALL, in LAST, drive HREADYOUT=1 and HRESP=0; the next state is chosen by REQ-020 from the pipelined address phase sampled at the same edge.
REQ-023 SHALL, in ERR1, drive HREADYOUT=0 and HRESP=1, then go to ERR2.
REQ-024 SHALL, in ERR2, drive HREADYOUT=1 and HRESP=1, then apply REQ-020; an errored transfer never touches memory.
REQ-025 SHALL commit a write as mem[addr_q] <= HWDATA at the edge that ends LAST.
REQ-026 SHALL drive HRDATA = mem[addr_q] in LAST of a read and 0 otherwise, so the read data is valid on the HREADYOUT=1 cycle.
REQ-027 SHALL return the newly written word when a read to the same address immediately follows a write (back-to-back).
REQ-028 SHALL give total data-phase latency of 1+WAIT_STATES cycles for OKAY transfers and exactly 2 cycles for ERROR.
REQ-029 SHALL ignore HTRANS/HSEL changes during WAIT/ERR1, since HREADY=0 prevents any accept.

Reset
REQ-030 SHALL, on HRESET=1, immediately force: state IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0, every memory word 0.
REQ-031 SHALL, on reset asserted mid-transfer (WAIT/LAST/ERR*), abort with no memory write; the first accept occurs at the first edge after deassertion.

Structure
REQ-032 SHALL take HTRANS encodings, HSIZE_WORD=010 and HRESP codes from shared package ahb_lite_pkg.
REQ-033 SHALL place the word array, write port and read mux in sub-module ahb_lite_slave_mem (params ADDR_W); the FSM and counter stay in the top level.

Verification
REQ-034 SHALL cover this scenario (WAIT_STATES=0): write 0x11111111 @0x04, then read @0x04 back-to-back -> HREADYOUT=1 throughout, HRESP=0, HRDATA=0x11111111 in the read data phase.
REQ-035 SHALL cover this scenario (WAIT_STATES=2): read @0x08 after a write of 0xAAAAAAAA -> HREADYOUT=0,0,1; HRDATA=0xAAAAAAAA only on the third cycle.
REQ-036 SHALL cover this scenario: HSIZE=000 @0x10, or HADDR=0x00000100 with ADDR_W=6 -> (HREADYOUT,HRESP)=(0,1),(1,1); a subsequent read @0x10 returns the prior value.
REQ-037 SHALL cover this scenario: HSEL=0 or HTRANS=IDLE with HWRITE=1 and HWDATA=0xDEADBEEF @0x0C -> no change; read @0x0C returns 0.
REQ-038 SHALL cover this scenario (WAIT_STATES=3): HRESET pulsed during WAIT of a write of 0x55555555 @0x14 -> outputs at reset values at once; read @0x14 returns 0.
REQ-039 SHALL cover this scenario (WAIT_STATES=1): write 0x22222222 @0x18 followed by a read @0x1C holding previous 0x0 -> correct pipelining; HRDATA=0x00000000 valid on the read's final cycle.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite definitions: transfer type codes, the word transfer size,
// response codes and the SRAM slave state encoding.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

endpackage

// File: rtl/ahb_lite_slave_mem.sv
// Word-addressed 32-bit storage for the AHB-Lite SRAM slave.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset, clears every word
//   we_i     write enable, commits wdata_i to addr_i at the rising edge
//   re_i     read enable, selects mem[addr_i] onto rdata_o (0 otherwise)
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  read data
module ahb_lite_slave_mem #(
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Combinational read: a write committed at the edge entering a read's
  // LAST cycle is already visible, which gives back-to-back forwarding.
  assign rdata_o = re_i ? mem_q[addr_i] : '0;

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave with a configurable number of wait states per OKAY
// data phase and a two-cycle ERROR response for illegal transfers.
// Ports:
//   HCLK       clock
//   HRESET     asynchronous active-high reset
//   HSEL       slave select
//   HADDR      byte address (address phase)
//   HTRANS     transfer type
//   HWRITE     1 = write, 0 = read
//   HSIZE      transfer size, only word is legal
//   HWDATA     write data (data phase)
//   HREADY     bus-wide ready
//   HREADYOUT  this slave's ready
//   HRESP      0 = OKAY, 1 = ERROR
//   HRDATA     read data, valid in the final cycle of a read
//
// state | meaning
// IDLE  | no data phase in progress
// WAIT  | OKAY data phase, inserting wait cycles (counter counts down)
// LAST  | final OKAY data-phase cycle; write commits at its closing edge
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  sram_state_e       state_q;
  logic [2:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic              ready_q;
  logic              resp_q;

  logic              accept;
  logic              xfer_err;
  logic              mem_we;
  logic              mem_re;

  assign accept = HSEL & HREADY &
                  ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  assign xfer_err = (HSIZE != HSIZE_WORD) |
                    (HADDR[1:0] != 2'b00) |
                    (HADDR[31:ADDR_W+2] != '0);

  // Outputs are registered: each branch sets ready/resp for the state it enters.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q <= ST_LAST;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_ERR1: begin
          state_q <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= HRESP_ERROR;
        end
        default: begin
          // IDLE, LAST and ERR2 all end with HREADYOUT high, so the
          // pipelined address phase is sampled here.
          if (accept) begin
            addr_q  <= HADDR[ADDR_W+1:2];
            write_q <= HWRITE;
            if (xfer_err) begin
              state_q <= ST_ERR1;
              ready_q <= 1'b0;
              resp_q  <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_INIT;
              ready_q <= 1'b0;
              resp_q  <= HRESP_OKAY;
            end else begin
              state_q <= ST_LAST;
              ready_q <= 1'b1;
              resp_q  <= HRESP_OKAY;
            end
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign mem_we = (state_q == ST_LAST) &  write_q;
  assign mem_re = (state_q == ST_LAST) & ~write_q;

  ahb_lite_slave_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_q),
    .wdata_i (HWDATA),
    .rdata_o (HRDATA)
  );

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;

endmodule
